// File: rtl/ps2_key_receiver.sv
// Host-side PS/2 keyboard receiver: synchronizes and filters the device-driven bus, deframes
// 11-bit frames into bytes and folds E0/F0 prefixes into one key event per scan code.
module ps2_key_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_break_o,
    output logic       key_ext_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);

    localparam logic [1:0] ErrStart   = 2'd0;
    localparam logic [1:0] ErrParity  = 2'd1;
    localparam logic [1:0] ErrStop    = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    localparam logic [7:0] ByteExt   = 8'hE0;
    localparam logic [7:0] ByteBreak = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers (reset to the idle-high bus level)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock glitch filter and falling-edge strobe
    // ------------------------------------------------------------------
    logic            flt_q;
    logic            flt_d;
    logic            flt_prev_q;
    logic [FltW-1:0] flt_cnt_q;
    logic [FltW-1:0] flt_cnt_d;
    logic            fall;

    // Counts consecutive samples that disagree with the filtered level.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_s != flt_q) begin
            if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
                flt_d = clk_s;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flt_q      <= 1'b1;
            flt_prev_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            flt_q      <= flt_d;
            flt_prev_q <= flt_q;
            flt_cnt_q  <= flt_cnt_d;
        end
    end

    assign fall = flt_prev_q & ~flt_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [3:0]      bit_cnt_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            rx_err_q;
    logic [1:0]      err_code_q;
    logic            par_ok;

    assign par_ok = ^{shift_q, par_q};

    // Frame checks resolve on the stop-bit edge, so the result is visible while in StDone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            err_code_q <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;

            if (fall || state_q != StRecv) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        if (!data_s) begin
                            state_q   <= StRecv;
                            bit_cnt_q <= 4'd1;
                            shift_q   <= '0;
                        end else begin
                            rx_err_q   <= 1'b1;
                            err_code_q <= ErrStart;
                        end
                    end
                end
                StRecv: begin
                    if (fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q <= 4'd8) begin
                            shift_q <= {data_s, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd9) begin
                            par_q <= data_s;
                        end else begin
                            state_q <= StDone;
                            if (!par_ok) begin
                                rx_err_q   <= 1'b1;
                                err_code_q <= ErrParity;
                            end else if (!data_s) begin
                                rx_err_q   <= 1'b1;
                                err_code_q <= ErrStop;
                            end else begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
                        state_q    <= StIdle;
                        rx_err_q   <= 1'b1;
                        err_code_q <= ErrTimeout;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key layer: fold prefix bytes into a single event
    // ------------------------------------------------------------------
    logic       ext_pend_q;
    logic       brk_pend_q;
    logic [7:0] key_code_q;
    logic       key_valid_q;
    logic       key_break_q;
    logic       key_ext_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (rx_err_q) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (rx_valid_q) begin
                if (rx_data_q == ByteExt) begin
                    ext_pend_q <= 1'b1;
                end else if (rx_data_q == ByteBreak) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= rx_data_q;
                    key_break_q <= brk_pend_q;
                    key_ext_q   <= ext_pend_q;
                    ext_pend_q  <= 1'b0;
                    brk_pend_q  <= 1'b0;
                end
            end
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_err_o    = rx_err_q;
    assign err_code_o  = err_code_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_break_o = key_break_q;
    assign key_ext_o   = key_ext_q;

endmodule
